// File: rtl/idct_da_pkg.sv
// Shared constants, FSM state type and basis-weight lookup for the 4-point
// distributed-arithmetic inverse DCT.
package idct_da_pkg;

  localparam int W_IN   = 12;
  localparam int W_ACC  = 24;
  localparam int FRAC   = 10;
  localparam int W_LUT  = 13;

  localparam int C_HALF = 512;
  localparam int C_1    = 669;
  localparam int C_3    = 277;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Q10 weight applied to coefficient k when reconstructing sample n.
  function automatic int basis(input int k, input int n);
    int w;
    w = 0;
    case (k)
      0: w = C_HALF;
      1: case (n)
           0:       w = C_1;
           1:       w = C_3;
           2:       w = -C_3;
           default: w = -C_1;
         endcase
      2: w = (n == 0 || n == 3) ? C_HALF : -C_HALF;
      default: case (n)
           0:       w = C_3;
           1:       w = -C_1;
           2:       w = C_1;
           default: w = -C_3;
         endcase
    endcase
    return w;
  endfunction

endpackage

// File: rtl/idct_da_lut.sv
// 16-entry partial-sum table for one output sample: entry = sum of the
// weights of every coefficient whose current bit is set.
module idct_da_lut
  import idct_da_pkg::*;
#(
  parameter int N = 0
) (
  input  logic [3:0]              i_addr,
  output logic signed [W_LUT-1:0] o_val
);

  logic signed [W_LUT-1:0] w_sum;

  // Address bit 3 carries Z0, bit 0 carries Z3.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (i_addr[3-k]) w_sum = w_sum + W_LUT'(basis(k, N));
    end
  end

  assign o_val = w_sum;

endmodule

// File: rtl/idct_da4.sv
// 4-point inverse DCT, bit-serial distributed arithmetic, MSB first; all four
// samples accumulate in parallel and are rounded/saturated on the OUT cycle.
module idct_da4 #(
  parameter int W_IN = 12,
  parameter int FRAC = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic signed [W_IN-1:0] Z0,
  input  logic signed [W_IN-1:0] Z1,
  input  logic signed [W_IN-1:0] Z2,
  input  logic signed [W_IN-1:0] Z3,
  input  logic                   IDA_start,
  output logic                   IDA_ready,
  output logic signed [W_IN-1:0] x0,
  output logic signed [W_IN-1:0] x1,
  output logic signed [W_IN-1:0] x2,
  output logic signed [W_IN-1:0] x3,
  output logic                   IDA_done,
  output idct_da_pkg::state_t    dbg_state
);
  import idct_da_pkg::*;

  // Handshake: a start is taken on any rising edge where IDA_start and
  // IDA_ready are both high; IDA_done is a single-cycle strobe with x0..x3
  // valid in that cycle and held afterwards.

  localparam int CW = $clog2(W_IN);
  localparam logic [CW-1:0] MSB = CW'(W_IN - 1);
  localparam logic signed [W_ACC-1:0] RND   = W_ACC'(2 ** (FRAC - 1));
  localparam logic signed [W_ACC-1:0] S_MAX = W_ACC'(2 ** (W_IN - 1) - 1);
  localparam logic signed [W_ACC-1:0] S_MIN = W_ACC'(-(2 ** (W_IN - 1)));

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [W_IN-1:0]  r_z   [4];
  logic signed [W_ACC-1:0] r_acc [4];
  logic signed [W_IN-1:0]  r_x   [4];
  logic                    r_done;

  logic                    w_accept;
  logic [3:0]              w_addr;
  logic signed [W_LUT-1:0] w_lut [4];
  logic signed [W_ACC-1:0] w_ext [4];
  logic signed [W_IN-1:0]  w_rnd [4];

  // Round half up, then clamp to the sample range.
  function automatic logic signed [W_IN-1:0] round_sat(input logic signed [W_ACC-1:0] a);
    logic signed [W_ACC-1:0] s;
    s = (a + RND) >>> FRAC;
    if (s > S_MAX)      round_sat = S_MAX[W_IN-1:0];
    else if (s < S_MIN) round_sat = S_MIN[W_IN-1:0];
    else                round_sat = s[W_IN-1:0];
  endfunction

  assign IDA_ready = (r_state != ST_ACC);
  assign w_accept  = IDA_start && IDA_ready;
  assign w_addr    = {r_z[0][r_cnt], r_z[1][r_cnt], r_z[2][r_cnt], r_z[3][r_cnt]};

  for (genvar n = 0; n < 4; n++) begin : g_lane
    idct_da_lut #(.N(n)) u_lut (
      .i_addr (w_addr),
      .o_val  (w_lut[n])
    );
    assign w_ext[n] = {{(W_ACC - W_LUT){w_lut[n][W_LUT-1]}}, w_lut[n]};
    assign w_rnd[n] = round_sat(r_acc[n]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_z[n]   <= '0;
        r_acc[n] <= '0;
        r_x[n]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ACC: begin
          // The MSB carries negative weight in two's complement.
          for (int n = 0; n < 4; n++) begin
            r_acc[n] <= (r_cnt == MSB) ? -w_ext[n] : (r_acc[n] <<< 1) + w_ext[n];
          end
          if (r_cnt == '0) r_state <= ST_OUT;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_OUT: begin
          for (int n = 0; n < 4; n++) r_x[n] <= w_rnd[n];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // A start in OUT overrides the return to IDLE, giving 13-clock throughput.
      if (w_accept) begin
        r_z[0]  <= Z0;
        r_z[1]  <= Z1;
        r_z[2]  <= Z2;
        r_z[3]  <= Z3;
        r_cnt   <= MSB;
        r_state <= ST_ACC;
      end
    end
  end

  assign x0        = r_x[0];
  assign x1        = r_x[1];
  assign x2        = r_x[2];
  assign x3        = r_x[3];
  assign IDA_done  = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_idct_da4.sv
// Bench for idct_da4: directed vector table, randomized vectors against a
// plain-arithmetic inverse DCT model, back-to-back, ignored starts, mid-ACC reset.
module tb_idct_da4;
  import idct_da_pkg::*;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic signed [11:0]  Z0, Z1, Z2, Z3;
  logic                IDA_start;
  logic                IDA_ready;
  logic signed [11:0]  x0, x1, x2, x3;
  logic                IDA_done;
  state_t              dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int wt [4][4];

  typedef struct {
    int z [4];
    int x [4];
  } vec_t;
  vec_t tbl [5];

  idct_da4 #(.W_IN(12), .FRAC(10)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .Z0        (Z0),
    .Z1        (Z1),
    .Z2        (Z2),
    .Z3        (Z3),
    .IDA_start (IDA_start),
    .IDA_ready (IDA_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .IDA_done  (IDA_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_x(input string tag, input int ex [4]);
    check({tag, ".x0"}, int'(x0), ex[0]);
    check({tag, ".x1"}, int'(x1), ex[1]);
    check({tag, ".x2"}, int'(x2), ex[2]);
    check({tag, ".x3"}, int'(x3), ex[3]);
  endtask

  // Reference: exact integer matrix product, floor((s+512)/1024), clamp.
  task automatic ref_model(input int z [4], output int x [4]);
    for (int n = 0; n < 4; n++) begin
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += wt[n][k] * z[k];
      s = (s + 512) >>> 10;
      if (s > 2047)  s = 2047;
      if (s < -2048) s = -2048;
      x[n] = s;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_z(input int z [4]);
    Z0 = 12'(z[0]);
    Z1 = 12'(z[1]);
    Z2 = 12'(z[2]);
    Z3 = 12'(z[3]);
  endtask

  task automatic scramble_z();
    Z0 = 12'($urandom);
    Z1 = 12'($urandom);
    Z2 = 12'($urandom);
    Z3 = 12'($urandom);
  endtask

  // Presents a start for one edge; caller guarantees the DUT is ready.
  task automatic start_x(input int z [4], input string tag);
    check({tag, ".ready_pre"}, int'(IDA_ready), 1);
    drive_z(z);
    IDA_start = 1'b1;
    @(posedge sys_clk); #1;
    IDA_start = 1'b0;
    scramble_z();
    check({tag, ".ready_acc"}, int'(IDA_ready), 0);
  endtask

  // Counts edges until IDA_done; optionally pulses start and scrambles Z in ACC.
  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    do begin
      @(posedge sys_clk); #1;
      lat++;
      if (noise) begin
        scramble_z();
        IDA_start = (dbg_state == ST_ACC) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end while (!IDA_done && lat < 40);
    IDA_start = 1'b0;
  endtask

  task automatic run_vec(input int z [4], input int ex [4], input string tag, input bit noise);
    int lat;
    start_x(z, tag);
    wait_done(noise, lat);
    check({tag, ".latency"}, lat, 13);
    check_x(tag, ex);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int z [4];
    int ex [4];
    int lat;

    wt[0] = '{512,  669,  512,  277};
    wt[1] = '{512,  277, -512, -669};
    wt[2] = '{512, -277, -512,  669};
    wt[3] = '{512, -669,  512, -277};

    tbl[0].z = '{0, 0, 0, 0};             tbl[0].x = '{0, 0, 0, 0};
    tbl[1].z = '{1024, 0, 0, 0};          tbl[1].x = '{512, 512, 512, 512};
    tbl[2].z = '{-2048, 0, 0, 0};         tbl[2].x = '{-1024, -1024, -1024, -1024};
    tbl[3].z = '{0, 1024, 0, 0};          tbl[3].x = '{669, 277, -277, -669};
    tbl[4].z = '{2047, 2047, 2047, 2047}; tbl[4].x = '{2047, -784, 784, 156};

    sys_rst_n = 1'b0;
    IDA_start = 1'b0;
    Z0 = '0; Z1 = '0; Z2 = '0; Z3 = '0;
    #22;
    check("rst.ready", int'(IDA_ready), 1);
    check("rst.done",  int'(IDA_done), 0);
    check("rst.state", int'(dbg_state), int'(ST_IDLE));
    check_x("rst", '{0, 0, 0, 0});
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Directed table, each start issued in the previous done cycle.
    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i].z, tbl[i].x, $sformatf("tbl%0d", i), 1'b0);
    end

    // Randomized vectors with ignored starts and Z churn during ACC.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) begin
        z[k] = (i < 2) ? ((i == 0) ? -2048 : 2047) : int'($urandom_range(0, 4095)) - 2048;
      end
      if (i == 1) z[1] = -2048;
      ref_model(z, ex);
      run_vec(z, ex, $sformatf("rnd%0d", i), 1'b1);
    end

    // Start taken in the OUT cycle: one transform per 13 clocks.
    start_x(tbl[3].z, "thr_a");
    repeat (12) begin
      @(posedge sys_clk); #1;
    end
    check("thr.state_out", int'(dbg_state), int'(ST_OUT));
    check("thr.ready_out", int'(IDA_ready), 1);
    check("thr.done_early", int'(IDA_done), 0);
    start_x(tbl[1].z, "thr_b");
    check("thr.done_a", int'(IDA_done), 1);
    check_x("thr_a", tbl[3].x);
    wait_done(1'b0, lat);
    check("thr.interval", lat, 13);
    check_x("thr_b", tbl[1].x);

    // Reset six clocks into ACC, then a clean transform.
    start_x(tbl[4].z, "mid");
    repeat (6) begin
      @(posedge sys_clk); #1;
    end
    check("mid.state_acc", int'(dbg_state), int'(ST_ACC));
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst.state", int'(dbg_state), int'(ST_IDLE));
    check("midrst.ready", int'(IDA_ready), 1);
    check("midrst.done",  int'(IDA_done), 0);
    check_x("midrst", '{0, 0, 0, 0});
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    run_vec(tbl[3].z, tbl[3].x, "post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
